store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 14 +
 rtl/store_buffer_byte_merge.sv | 16 +
 rtl/store_buffer.sv | 128 ++++++++++++
 tb/tb_store_buffer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// Shared defaults and entry layout for the store buffer slice.
package sb_pkg;

  localparam int unsigned SB_DEPTH = 4;
  localparam int unsigned SB_AW    = 10;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] pc;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_byte_merge.sv
// Per-lane overlay: enabled bytes of one buffered store replace bytes of the base word.
module sb_byte_merge (
  input  logic [31:0] base,
  input  logic [31:0] data,
  input  logic [3:0]  be,
  output logic [31:0] merged
);

  always_comb begin
    merged = base;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = data[8*i +: 8];
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between MEM and data memory, drained one entry per cycle.
// Build option: STORE_BUFFER_FWD_EN enables load forwarding; otherwise matching loads stall.
module store_buffer
  import sb_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH,
  parameter int unsigned AW    = SB_AW
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        st_valid,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_wdata,
  input  logic [3:0]  st_be,
  input  logic [31:0] st_pc,
  output logic        st_ready,
  input  logic        ld_valid,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_dm_rd,
  output logic [31:0] ld_data,
  output logic        ld_stall,
  input  logic        dm_ready,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wd,
  output logic [31:0] dm_pc,
  output logic [3:0]  dm_be
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  sb_entry_t     entries_q [DEPTH];
  sb_entry_t     entries_d [DEPTH];
  sb_entry_t     head_entry;
  logic          push, drain;
  logic [DEPTH-1:0] hit;
  logic          unused_ld_addr;

  assign unused_ld_addr = ^{ld_addr[31:AW+2], ld_addr[1:0]};

  always_comb begin
    st_ready   = reset || (count_q != FULL);
    push       = st_valid && !reset && (count_q != FULL);
    drain      = dm_ready && !reset && (count_q != '0);
    head_entry = entries_q[head_q];
    dm_we      = drain;
    dm_addr    = head_entry.addr;
    dm_wd      = head_entry.wdata;
    dm_be      = head_entry.be;
    dm_pc      = head_entry.pc;

    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;
    entries_d = entries_q;
    if (push) begin
      entries_d[tail_q] = '{addr: st_addr, wdata: st_wdata, be: st_be, pc: st_pc};
      tail_d = tail_q + 1'b1;
    end
    if (drain) head_d = head_q + 1'b1;
    case ({push, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is never cleared; count_q alone qualifies which slots are live.
  always_ff @(posedge clk) begin
    entries_q <= entries_d;
  end

  // hit[k] is indexed by age (k = 0 is the oldest live entry), not by slot.
  always_comb begin
    hit = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      hit[k] = !reset && (CW'(k) < count_q) &&
               (entries_q[head_q + PW'(k)].addr[AW+1:2] == ld_addr[AW+1:2]);
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [31:0] ord_data [DEPTH];
  logic [3:0]  ord_be   [DEPTH];
  logic [31:0] chain    [DEPTH+1];

  always_comb begin
    for (int unsigned k = 0; k < DEPTH; k++) begin
      ord_data[k] = entries_q[head_q + PW'(k)].wdata;
      ord_be[k]   = hit[k] ? entries_q[head_q + PW'(k)].be : 4'b0000;
    end
  end

  assign chain[0] = ld_dm_rd;

  for (genvar g = 0; g < DEPTH; g++) begin : g_merge
    sb_byte_merge u_merge (
      .base   (chain[g]),
      .data   (ord_data[g]),
      .be     (ord_be[g]),
      .merged (chain[g+1])
    );
  end

  assign ld_data  = ld_valid ? chain[DEPTH] : ld_dm_rd;
  assign ld_stall = 1'b0;
`else
  assign ld_data  = ld_dm_rd;
  assign ld_stall = ld_valid && (|hit);
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer (DEPTH=4, AW=10) against a queue-based reference model.
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr, st_wdata, st_pc;
  logic [3:0]  st_be;
  logic        st_ready;
  logic        ld_valid;
  logic [31:0] ld_addr, ld_dm_rd, ld_data;
  logic        ld_stall;
  logic        dm_ready;
  logic        dm_we;
  logic [31:0] dm_addr, dm_wd, dm_pc;
  logic [3:0]  dm_be;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] pc;
  } ent_t;

  ent_t mq[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  store_buffer #(.DEPTH(4), .AW(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .st_valid (st_valid),
    .st_addr  (st_addr),
    .st_wdata (st_wdata),
    .st_be    (st_be),
    .st_pc    (st_pc),
    .st_ready (st_ready),
    .ld_valid (ld_valid),
    .ld_addr  (ld_addr),
    .ld_dm_rd (ld_dm_rd),
    .ld_data  (ld_data),
    .ld_stall (ld_stall),
    .dm_ready (dm_ready),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wd    (dm_wd),
    .dm_pc    (dm_pc),
    .dm_be    (dm_be)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit same_word(input logic [31:0] a, input logic [31:0] b);
    return a[11:2] == b[11:2];
  endfunction

  task automatic compare_all();
    bit          exp_ready, exp_we, exp_stall, any_hit;
    logic [31:0] exp_data;
    exp_ready = reset || (mq.size() < 4);
    exp_we    = !reset && (mq.size() != 0) && dm_ready;
    check("st_ready", 32'(st_ready), 32'(exp_ready));
    check("dm_we", 32'(dm_we), 32'(exp_we));
    if (exp_we) begin
      check("dm_addr", dm_addr, mq[0].addr);
      check("dm_wd", dm_wd, mq[0].wdata);
      check("dm_be", 32'(dm_be), 32'(mq[0].be));
      check("dm_pc", dm_pc, mq[0].pc);
    end
    any_hit  = 1'b0;
    exp_data = ld_dm_rd;
    if (!reset) begin
      foreach (mq[i]) begin
        if (same_word(mq[i].addr, ld_addr)) begin
          any_hit = 1'b1;
          for (int l = 0; l < 4; l++)
            if (mq[i].be[l]) exp_data[8*l +: 8] = mq[i].wdata[8*l +: 8];
        end
      end
    end
`ifdef STORE_BUFFER_FWD_EN
    exp_stall = 1'b0;
`else
    exp_stall = ld_valid && any_hit;
    exp_data  = ld_dm_rd;
`endif
    check("ld_stall", 32'(ld_stall), 32'(exp_stall));
    if (ld_valid) check("ld_data", ld_data, exp_data);
  endtask

  task automatic model_update();
    bit do_drain, do_push;
    if (reset) begin
      mq.delete();
    end else begin
      do_drain = (mq.size() != 0) && dm_ready;
      do_push  = st_valid && (mq.size() < 4);
      if (do_drain) void'(mq.pop_front());
      if (do_push) mq.push_back('{addr: st_addr, wdata: st_wdata, be: st_be, pc: st_pc});
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_store(input bit v, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be, input logic [31:0] pc);
    st_valid = v; st_addr = a; st_wdata = d; st_be = be; st_pc = pc;
  endtask

  initial begin
    int   accept_iter;
    logic [31:0] a;
    reset = 1'b1; dm_ready = 1'b0;
    set_store(1'b0, '0, '0, '0, '0);
    ld_valid = 1'b0; ld_addr = '0; ld_dm_rd = 32'h5a5a_0000;
    step(); step();
    reset = 1'b0;
    #1;
    check("reset_st_ready", 32'(st_ready), 32'd1);
    check("reset_dm_we", 32'(dm_we), 32'd0);

    // Single word store drains the cycle after it is pushed.
    dm_ready = 1'b1;
    set_store(1'b1, 32'h10, 32'h1122_3344, 4'b1111, 32'h1000);
    #1;
    check("push_empty_no_drain", 32'(dm_we), 32'd0);
    step();
    set_store(1'b0, '0, '0, '0, '0);
    #1;
    check("first_drain_we", 32'(dm_we), 32'd1);
    check("first_drain_addr", dm_addr, 32'h10);
    check("first_drain_wd", dm_wd, 32'h1122_3344);
    check("first_drain_be", 32'(dm_be), 32'hf);
    step();
    #1;
    check("empty_after_drain", 32'(dm_we), 32'd0);
    step();

    // Fill to DEPTH with memory busy, hold a fifth store, then release.
    dm_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_store(1'b1, 32'h40 + 32'(4 * i), 32'hc0de_0000 + 32'(i), 4'b1111, 32'h2000 + 32'(4 * i));
      step();
    end
    set_store(1'b1, 32'h50, 32'hc0de_0004, 4'b1111, 32'h2010);
    #1;
    check("full_st_ready", 32'(st_ready), 32'd0);
    step();
    dm_ready = 1'b1;
    accept_iter = -1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (st_ready) begin
        accept_iter = i;
        step();
        break;
      end
      step();
    end
    check("fifth_accept_cycle", 32'(accept_iter), 32'd1);
    set_store(1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 5; i++) step();

`ifdef STORE_BUFFER_FWD_EN
    dm_ready = 1'b0;
    set_store(1'b1, 32'h20, 32'haabb_ccdd, 4'b1111, 32'h3000); step();
    set_store(1'b1, 32'h21, 32'h0000_7700, 4'b0010, 32'h3004); step();
    set_store(1'b0, '0, '0, '0, '0);
    ld_valid = 1'b1; ld_addr = 32'h20; ld_dm_rd = 32'h0;
    #1;
    check("fwd_merge", ld_data, 32'haabb_77dd);
    check("fwd_no_stall", 32'(ld_stall), 32'd0);
    step();
    ld_valid = 1'b0; dm_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
`else
    dm_ready = 1'b0;
    set_store(1'b1, 32'h30, 32'h1234_5678, 4'b1111, 32'h3000); step();
    set_store(1'b0, '0, '0, '0, '0);
    ld_valid = 1'b1; ld_addr = 32'h30; ld_dm_rd = 32'h9999_0000;
    #1;
    check("nofwd_stall_match", 32'(ld_stall), 32'd1);
    check("nofwd_data_passthru", ld_data, 32'h9999_0000);
    step();
    ld_addr = 32'h34;
    #1;
    check("nofwd_other_word", 32'(ld_stall), 32'd0);
    step();
    ld_addr = 32'h30; dm_ready = 1'b1;
    step();
    #1;
    check("nofwd_release", 32'(ld_stall), 32'd0);
    step();
    ld_valid = 1'b0;
`endif

    // Nine back-to-back push/drain pairs wrap the pointers twice.
    dm_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_store(1'b1, 32'h80 + 32'(4 * i), $urandom, 4'b1111, 32'h4000 + 32'(i));
      step();
    end
    set_store(1'b0, '0, '0, '0, '0);
    step(); step();

    // Reset with three pending entries discards them.
    dm_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_store(1'b1, 32'hc0 + 32'(4 * i), $urandom, 4'b0011, 32'h5000 + 32'(i));
      step();
    end
    set_store(1'b0, '0, '0, '0, '0);
    reset = 1'b1; dm_ready = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check("post_reset_we", 32'(dm_we), 32'd0);
    check("post_reset_ready", 32'(st_ready), 32'd1);
    for (int i = 0; i < 3; i++) step();

    // Random traffic over a small address pool, including aliases above bit 11.
    for (int i = 0; i < 600; i++) begin
      int unsigned sz;
      reset    = ($urandom_range(0, 79) == 0);
      dm_ready = ($urandom_range(0, 9) < 6);
      a  = 32'h100 + 32'($urandom_range(0, 3) * 4);
      if ($urandom_range(0, 7) == 0) a[12] = 1'b1;
      sz = $urandom_range(0, 2);
      if (sz == 0) begin
        st_be = 4'b1111;
      end else if (sz == 1) begin
        a[1] = 1'($urandom_range(0, 1));
        st_be = a[1] ? 4'b1100 : 4'b0011;
      end else begin
        a[1:0] = 2'($urandom_range(0, 3));
        st_be = 4'b0001 << a[1:0];
      end
      st_valid = 1'($urandom_range(0, 1));
      st_addr  = a;
      st_wdata = $urandom;
      st_pc    = 32'h8000 + 32'(i * 4);
      ld_valid = 1'($urandom_range(0, 1));
      ld_addr  = 32'h100 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) ld_addr[13] = 1'b1;
      ld_dm_rd = $urandom;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
